// File: rtl/tile_rst_pkg.sv
// ----------------------------------------------------------------------------
// tile_rst_pkg
// Shared types and width helpers for the tile reset sequencer.
//   rst_seq_state_e : sequencer states (IDLE -> WAKE -> RELEASE -> RUN)
//   cnt_width()     : width of a down-counter that must hold 0..max_val
//   idx_width()     : width of an index over n channels (at least 1 bit)
// ----------------------------------------------------------------------------
package tile_rst_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAKE    = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } rst_seq_state_e;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rst_sync_async_assert.sv
// ----------------------------------------------------------------------------
// rst_sync_async_assert
// Reset synchroniser: asserts asynchronously with reset_l, deasserts
// SyncStages clk_i edges after reset_l rises.
//   clk_i      : clock
//   reset_l    : raw reset, asynchronous, active-low
//   rst_sync_n : synchronised reset, active-low
// ----------------------------------------------------------------------------
module rst_sync_async_assert #(
  parameter int SyncStages = 2
) (
  input  logic clk_i,
  input  logic reset_l,
  output logic rst_sync_n
);

  logic [SyncStages-1:0] sync_reg;

  // A constant 1 ripples through the chain once reset_l is released.
  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SyncStages-2:0], 1'b1};
    end
  end

  assign rst_sync_n = sync_reg[SyncStages-1];

endmodule

// File: rtl/tile_reset_sequencer.sv
// ----------------------------------------------------------------------------
// tile_reset_sequencer
// Wake-up delay followed by a staggered release of NumChannels reset outputs,
// plus a per-channel soft-reset path with a minimum hold and release ack.
//   clk_i          : clock
//   reset_l        : tile reset, asynchronous, active-low
//   soft_rst_req_i : per-channel soft-reset request (level)
//   rst_no         : per-channel reset, active-low
//   soft_rst_ack_o : one-cycle pulse when a channel leaves a soft-reset hold
//   wake_done_o    : wake-up delay elapsed
//   all_released_o : sequence finished and every channel out of reset
// ----------------------------------------------------------------------------
module tile_reset_sequencer
  import tile_rst_pkg::*;
#(
  parameter int NumChannels    = 2,
  parameter int WakeCntWidth   = 16,
  parameter int SyncStages     = 2,
  parameter int StaggerCycles  = 4,
  parameter int SoftHoldCycles = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_l,
  input  logic [NumChannels-1:0] soft_rst_req_i,
  output logic [NumChannels-1:0] rst_no,
  output logic [NumChannels-1:0] soft_rst_ack_o,
  output logic                   wake_done_o,
  output logic                   all_released_o
);

  localparam int StagWidth = cnt_width(StaggerCycles);
  localparam int HoldWidth = cnt_width(SoftHoldCycles);
  localparam int IdxWidth  = idx_width(NumChannels);

  // Counters are loaded with N-1 so the action lands exactly N edges after
  // the loading edge (the loading edge itself is cycle 0 of the wait).
  localparam logic [StagWidth-1:0] StagReload = StagWidth'(StaggerCycles - 1);
  localparam logic [HoldWidth-1:0] HoldReload = HoldWidth'(SoftHoldCycles - 1);
  localparam logic [IdxWidth-1:0]  LastIdx    = IdxWidth'(NumChannels - 1);

  logic rst_sync_n;

  rst_sync_async_assert #(
    .SyncStages(SyncStages)
  ) u_rst_sync (
    .clk_i     (clk_i),
    .reset_l   (reset_l),
    .rst_sync_n(rst_sync_n)
  );

  rst_seq_state_e        state_reg;
  logic [WakeCntWidth-1:0] wake_cnt_reg;
  logic [WakeCntWidth-1:0] wake_cnt_inc;
  logic [StagWidth-1:0]  stag_cnt_reg;
  logic [IdxWidth-1:0]   idx_reg;
  logic                  wake_done_reg;
  logic                  all_released_reg;

  logic                   seq_active;
  logic                   slot_open;
  logic                   seq_done_next;
  logic [NumChannels-1:0] rst_n_next;

  assign wake_cnt_inc  = wake_cnt_reg + 1'b1;
  assign seq_active    = (state_reg == RELEASE) || (state_reg == RUN);
  assign slot_open     = (state_reg == RELEASE) && (stag_cnt_reg == '0);
  assign seq_done_next = (state_reg == RUN) || (slot_open && (idx_reg == LastIdx));

  // Sequencer FSM. The IDLE cycle already counts toward the wake delay so
  // the delay is exactly SyncStages + 2^(WakeCntWidth-1) edges from reset_l.
  always_ff @(posedge clk_i or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_reg        <= IDLE;
      wake_cnt_reg     <= '0;
      stag_cnt_reg     <= '0;
      idx_reg          <= '0;
      wake_done_reg    <= 1'b0;
      all_released_reg <= 1'b0;
    end else begin
      all_released_reg <= seq_done_next & (&rst_n_next);
      case (state_reg)
        IDLE: begin
          state_reg    <= WAKE;
          wake_cnt_reg <= wake_cnt_inc;
        end
        WAKE: begin
          wake_cnt_reg <= wake_cnt_inc;
          if (wake_cnt_inc[WakeCntWidth-1]) begin
            wake_done_reg <= 1'b1;
            state_reg     <= RELEASE;
            idx_reg       <= '0;
            stag_cnt_reg  <= '0;
          end
        end
        RELEASE: begin
          if (stag_cnt_reg == '0) begin
            if (idx_reg == LastIdx) begin
              state_reg <= RUN;
            end else begin
              idx_reg      <= idx_reg + 1'b1;
              stag_cnt_reg <= StagReload;
            end
          end else begin
            stag_cnt_reg <= stag_cnt_reg - 1'b1;
          end
        end
        RUN: begin
          state_reg <= RUN;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign wake_done_o    = wake_done_reg;
  assign all_released_o = all_released_reg;

  // Per-channel release and soft-reset hold.
  for (genvar gi = 0; gi < NumChannels; gi++) begin : g_chan
    logic                 sched_reg, sched_next;
    logic                 hold_reg, hold_next;
    logic [HoldWidth-1:0] hold_cnt_reg, hold_cnt_next;
    logic                 chan_rst_n_reg, chan_rst_n_next;
    logic                 ack_reg, ack_next;
    logic                 my_slot;

    assign my_slot = slot_open && (idx_reg == IdxWidth'(gi));

    always_comb begin
      sched_next      = sched_reg;
      hold_next       = hold_reg;
      hold_cnt_next   = hold_cnt_reg;
      chan_rst_n_next = chan_rst_n_reg;
      ack_next        = 1'b0;
      if (seq_active) begin
        if (!sched_reg) begin
          // A request pending at the release slot turns the release into a
          // soft-reset hold; the stagger keeps moving regardless.
          if (my_slot) begin
            sched_next = 1'b1;
            if (soft_rst_req_i[gi]) begin
              hold_next     = 1'b1;
              hold_cnt_next = HoldReload;
            end else begin
              chan_rst_n_next = 1'b1;
            end
          end
        end else if (hold_reg) begin
          if (hold_cnt_reg == '0) begin
            if (!soft_rst_req_i[gi]) begin
              hold_next       = 1'b0;
              chan_rst_n_next = 1'b1;
              ack_next        = 1'b1;
            end
          end else begin
            hold_cnt_next = hold_cnt_reg - 1'b1;
          end
        end else if (soft_rst_req_i[gi]) begin
          hold_next       = 1'b1;
          hold_cnt_next   = HoldReload;
          chan_rst_n_next = 1'b0;
        end
      end
    end

    always_ff @(posedge clk_i or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
        sched_reg      <= 1'b0;
        hold_reg       <= 1'b0;
        hold_cnt_reg   <= '0;
        chan_rst_n_reg <= 1'b0;
        ack_reg        <= 1'b0;
      end else begin
        sched_reg      <= sched_next;
        hold_reg       <= hold_next;
        hold_cnt_reg   <= hold_cnt_next;
        chan_rst_n_reg <= chan_rst_n_next;
        ack_reg        <= ack_next;
      end
    end

    assign rst_n_next[gi]     = chan_rst_n_next;
    assign rst_no[gi]         = chan_rst_n_reg;
    assign soft_rst_ack_o[gi] = ack_reg;
  end

endmodule

// File: tb/tb_tile_reset_sequencer.sv
// ----------------------------------------------------------------------------
// tb_tile_reset_sequencer
// Self-checking bench for tile_reset_sequencer with a small configuration
// (WakeCntWidth=4, SyncStages=2, StaggerCycles=4, SoftHoldCycles=8, 2 ch).
// Expected output vectors {rst_no, soft_rst_ack_o, wake_done_o,
// all_released_o} are derived from the edge-timing formulas, queued when the
// stimulus for an edge is driven and popped once that edge has happened.
// ----------------------------------------------------------------------------
module tb_tile_reset_sequencer;

  localparam int N  = 2;
  localparam int WW = 4;
  localparam int SS = 2;
  localparam int ST = 4;
  localparam int SH = 8;
  localparam int D  = SS + (1 << (WW - 1));
  localparam int LAST_REL = D + 1 + (N - 1) * ST;

  logic         clk_i = 1'b0;
  logic         reset_l = 1'b0;
  logic [N-1:0] soft_rst_req_i = '0;
  logic [N-1:0] rst_no;
  logic [N-1:0] soft_rst_ack_o;
  logic         wake_done_o;
  logic         all_released_o;

  int tests_run    = 0;
  int tests_failed = 0;
  int edge_n       = 0;

  typedef struct {
    int         edge_idx;
    logic [5:0] v;
  } exp_t;

  exp_t sb[$];

  tile_reset_sequencer #(
    .NumChannels   (N),
    .WakeCntWidth  (WW),
    .SyncStages    (SS),
    .StaggerCycles (ST),
    .SoftHoldCycles(SH)
  ) dut (
    .clk_i         (clk_i),
    .reset_l       (reset_l),
    .soft_rst_req_i(soft_rst_req_i),
    .rst_no        (rst_no),
    .soft_rst_ack_o(soft_rst_ack_o),
    .wake_done_o   (wake_done_o),
    .all_released_o(all_released_o)
  );

  always #5 clk_i = ~clk_i;

  // Vector layout: {rst1, rst0, ack1, ack0, wake_done, all_released}
  function automatic logic [5:0] base_vec(input int e);
    logic r0, r1, wd, ar;
    r0 = (e >= D + 1);
    r1 = (e >= D + 1 + ST);
    wd = (e >= D);
    ar = (e >= LAST_REL);
    return {r1, r0, 2'b00, wd, ar};
  endfunction

  function automatic logic [5:0] observed();
    return {rst_no, soft_rst_ack_o, wake_done_o, all_released_o};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    edge_n++;
    #1;
  endtask

  // Hold reset for a few cycles, then release it 1 time unit after an edge
  // so that the next rising edge is edge 1.
  task automatic start_sequence(input logic [N-1:0] pre_req);
    reset_l        = 1'b0;
    soft_rst_req_i = pre_req;
    repeat (3) @(posedge clk_i);
    #1;
    reset_l = 1'b1;
    edge_n  = 0;
  endtask

  task automatic test_reset();
    logic [5:0] got;
    reset_l        = 1'b0;
    soft_rst_req_i = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i);
      #1;
      got = observed();
      tests_run++;
      if (got !== 6'b0) begin
        tests_failed++;
        $display("FAIL reset_state cycle %0d: got %b required %b", i, got, 6'b0);
      end
    end
  endtask

  task automatic test_power_on();
    exp_t x;
    logic [5:0] got;
    start_sequence('0);
    for (int e = 1; e <= 20; e++) begin
      soft_rst_req_i = '0;
      sb.push_back('{e, base_vec(e)});
      tick();
      x   = sb.pop_front();
      got = observed();
      tests_run++;
      if (got !== x.v || edge_n != x.edge_idx) begin
        tests_failed++;
        $display("FAIL power_on edge %0d: got %b required %b", x.edge_idx, got, x.v);
      end
    end
  endtask

  task automatic test_soft_pulse();
    exp_t x;
    logic [5:0] want, got;
    start_sequence('0);
    for (int e = 1; e <= 42; e++) begin
      soft_rst_req_i = {(e == 30), 1'b0};
      want = base_vec(e);
      if (e >= 30 && e < 30 + SH) begin
        want[5] = 1'b0;
        want[0] = 1'b0;
      end
      if (e == 30 + SH) want[3] = 1'b1;
      sb.push_back('{e, want});
      tick();
      x   = sb.pop_front();
      got = observed();
      tests_run++;
      if (got !== x.v) begin
        tests_failed++;
        $display("FAIL soft_pulse edge %0d: got %b required %b", x.edge_idx, got, x.v);
      end
    end
  endtask

  task automatic test_long_request();
    exp_t x;
    logic [5:0] want, got;
    start_sequence('0);
    for (int e = 1; e <= 50; e++) begin
      soft_rst_req_i = {1'b0, (e >= 30 && e <= 44)};
      want = base_vec(e);
      if (e >= 30 && e < 45) begin
        want[4] = 1'b0;
        want[0] = 1'b0;
      end
      if (e == 45) want[2] = 1'b1;
      sb.push_back('{e, want});
      tick();
      x   = sb.pop_front();
      got = observed();
      tests_run++;
      if (got !== x.v) begin
        tests_failed++;
        $display("FAIL long_request edge %0d: got %b required %b", x.edge_idx, got, x.v);
      end
    end
  endtask

  task automatic test_held_from_start();
    exp_t x;
    logic [5:0] want, got;
    start_sequence(2'b10);
    for (int e = 1; e <= 32; e++) begin
      soft_rst_req_i = {(e <= 25), 1'b0};
      want    = base_vec(e);
      want[5] = (e >= 26);
      want[3] = (e == 26);
      want[0] = (e >= 26);
      sb.push_back('{e, want});
      tick();
      x   = sb.pop_front();
      got = observed();
      tests_run++;
      if (got !== x.v) begin
        tests_failed++;
        $display("FAIL held_from_start edge %0d: got %b required %b", x.edge_idx, got, x.v);
      end
    end
  endtask

  task automatic test_simultaneous();
    exp_t x;
    logic [5:0] want, got;
    start_sequence('0);
    for (int e = 1; e <= 50; e++) begin
      soft_rst_req_i = (e == 40) ? 2'b11 : 2'b00;
      want = base_vec(e);
      if (e >= 40 && e < 40 + SH) begin
        want[5:4] = 2'b00;
        want[0]   = 1'b0;
      end
      if (e == 40 + SH) want[3:2] = 2'b11;
      sb.push_back('{e, want});
      tick();
      x   = sb.pop_front();
      got = observed();
      tests_run++;
      if (got !== x.v) begin
        tests_failed++;
        $display("FAIL simultaneous edge %0d: got %b required %b", x.edge_idx, got, x.v);
      end
    end
  endtask

  task automatic test_reset_midway();
    exp_t x;
    logic [5:0] got;
    start_sequence('0);
    for (int e = 1; e <= 13; e++) begin
      soft_rst_req_i = '0;
      sb.push_back('{e, base_vec(e)});
      tick();
      x   = sb.pop_front();
      got = observed();
      tests_run++;
      if (got !== x.v) begin
        tests_failed++;
        $display("FAIL midway_pre edge %0d: got %b required %b", x.edge_idx, got, x.v);
      end
    end
    // Outputs must clear without waiting for a clock edge.
    reset_l = 1'b0;
    #1;
    got = observed();
    tests_run++;
    if (got !== 6'b0) begin
      tests_failed++;
      $display("FAIL midway_async_clear: got %b required %b", got, 6'b0);
    end
    repeat (2) @(posedge clk_i);
    #1;
    got = observed();
    tests_run++;
    if (got !== 6'b0) begin
      tests_failed++;
      $display("FAIL midway_held: got %b required %b", got, 6'b0);
    end
    reset_l = 1'b1;
    edge_n  = 0;
    for (int e = 1; e <= 20; e++) begin
      soft_rst_req_i = '0;
      sb.push_back('{e, base_vec(e)});
      tick();
      x   = sb.pop_front();
      got = observed();
      tests_run++;
      if (got !== x.v) begin
        tests_failed++;
        $display("FAIL midway_restart edge %0d: got %b required %b", x.edge_idx, got, x.v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_soft_pulse();
    test_long_request();
    test_held_from_start();
    test_simultaneous();
    test_reset_midway();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
